// File: rtl/beeb_bus_bridge.sv
// Turns one held core request into a single Beeb 6502 bus cycle aligned to host Phi0.
// Also drives Phi1/Phi2 and the slowdown counter that follows writes to FE40.
module beeb_bus_bridge #(
    parameter int NPHI0_REGS = 5,
    parameter int PHIOUT_TAP = 1,
    parameter int SLOW_SOUND = 15,
    parameter int SLOW_KBD   = 1
) (
    input  logic        cpu_clk,
    input  logic        cpu_reset,
    input  logic        phi_in,
    input  logic        req,
    input  logic [15:0] req_addr,
    input  logic        req_we,
    input  logic [7:0]  req_dout,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        slow,
    output logic        phi1_out,
    output logic        phi2_out,
    output logic [15:0] bus_addr,
    output logic        bus_rnw,
    output logic [7:0]  bus_dout,
    output logic        bus_doe,
    input  logic [7:0]  data_in
);
    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t                r_state;
    logic [NPHI0_REGS-1:0] r_phi;
    logic [7:0]            r_data_q;
    logic                  r_cycle_start;
    logic [3:0]            r_slow_cnt;
    logic [15:0]           r_bus_addr;
    logic                  r_bus_rnw;
    logic [7:0]            r_bus_dout;
    logic                  r_ack;
    logic [7:0]            r_rdata;

    logic w_cycle_end;
    logic w_phi2_fall;
    logic w_fe40_wr;

    // The tail of the chain sees Phi0 fall late enough that the host cycle has really ended.
    assign w_cycle_end = r_phi[NPHI0_REGS-1] & ~r_phi[NPHI0_REGS-2];
    assign w_phi2_fall = r_phi[PHIOUT_TAP+1] & ~r_phi[PHIOUT_TAP];
    assign w_fe40_wr   = (r_state == S_ACTIVE) & ~r_bus_rnw & (r_bus_addr == 16'hFE40);

    always_ff @(posedge cpu_clk) begin
        if (cpu_reset) begin
            r_phi         <= '0;
            r_data_q      <= 8'hFF;
            r_cycle_start <= 1'b0;
        end else begin
            r_phi         <= {r_phi[NPHI0_REGS-2:0], phi_in};
            r_data_q      <= data_in;
            r_cycle_start <= w_cycle_end;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_reset) begin
            r_state    <= S_IDLE;
            r_bus_addr <= 16'hFFFF;
            r_bus_rnw  <= 1'b1;
            r_bus_dout <= 8'hFF;
            r_ack      <= 1'b0;
            r_rdata    <= 8'hFF;
        end else begin
            r_ack <= 1'b0;
            if (w_phi2_fall && (r_state == S_ACTIVE) && r_bus_rnw)
                r_rdata <= r_data_q;
            case (r_state)
                S_IDLE: begin
                    // Bus keeps the last access until here, giving address hold time.
                    if (r_cycle_start) begin
                        if (req) begin
                            r_bus_addr <= req_addr;
                            r_bus_rnw  <= ~req_we;
                            r_bus_dout <= req_dout;
                            r_state    <= S_ACTIVE;
                        end else begin
                            r_bus_addr <= 16'hFFFF;
                            r_bus_rnw  <= 1'b1;
                            r_bus_dout <= 8'hFF;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (w_cycle_end) begin
                        r_ack   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_reset) begin
            r_slow_cnt <= 4'd0;
        end else if (w_cycle_end) begin
            if (w_fe40_wr)
                r_slow_cnt <= (r_bus_dout[2:0] == 3'b000) ? 4'(SLOW_SOUND) : 4'(SLOW_KBD);
            else if (r_slow_cnt != 4'd0)
                r_slow_cnt <= r_slow_cnt - 4'd1;
        end
    end

    assign ack      = r_ack;
    assign rdata    = r_rdata;
    assign slow     = |r_slow_cnt;
    assign phi1_out = ~r_phi[PHIOUT_TAP];
    assign phi2_out = r_phi[PHIOUT_TAP];
    assign bus_addr = r_bus_addr;
    assign bus_rnw  = r_bus_rnw;
    assign bus_dout = r_bus_dout;
    assign bus_doe  = ~r_bus_rnw & r_phi[0];
endmodule

// File: tb/tb_beeb_bus_bridge.sv
// Bench for beeb_bus_bridge: vector table of accesses, hand-written corner sequences,
// and random traffic, all compared each cycle against a history-based reference model.
`timescale 1ns/1ps
module tb_beeb_bus_bridge;
    localparam int NPHI = 5;
    localparam int TAP  = 1;

    logic        cpu_clk = 1'b0;
    logic        cpu_reset = 1'b1;
    logic        phi_in = 1'b0;
    logic        req = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic        req_we = 1'b0;
    logic [7:0]  req_dout = 8'h00;
    logic [7:0]  data_in = 8'hFF;
    logic        ack, slow, phi1_out, phi2_out, bus_rnw, bus_doe;
    logic [7:0]  rdata, bus_dout;
    logic [15:0] bus_addr;

    beeb_bus_bridge #(.NPHI0_REGS(NPHI), .PHIOUT_TAP(TAP), .SLOW_SOUND(15), .SLOW_KBD(1)) dut (
        .cpu_clk(cpu_clk), .cpu_reset(cpu_reset), .phi_in(phi_in), .req(req),
        .req_addr(req_addr), .req_we(req_we), .req_dout(req_dout), .ack(ack),
        .rdata(rdata), .slow(slow), .phi1_out(phi1_out), .phi2_out(phi2_out),
        .bus_addr(bus_addr), .bus_rnw(bus_rnw), .bus_dout(bus_dout), .bus_doe(bus_doe),
        .data_in(data_in)
    );

    always #5 cpu_clk = ~cpu_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: phi_in history (bit 0 = most recent sample) plus one open transaction.
    logic [15:0] m_hist;
    logic        m_ce_prev, m_busy, m_we, m_ack, ev_ce;
    logic [15:0] m_addr;
    logic [7:0]  m_dout, m_rdata, m_dprev;
    int          m_slow;

    task automatic model_update();
        logic ce, cs, fall2;
        if (cpu_reset) begin
            m_hist = '0; m_ce_prev = 0; m_dprev = 8'hFF; m_busy = 0; m_we = 0;
            m_addr = 16'hFFFF; m_dout = 8'hFF; m_ack = 0; m_rdata = 8'hFF;
            m_slow = 0; ev_ce = 0;
            return;
        end
        ce    = m_hist[NPHI-1] & !m_hist[NPHI-2];
        cs    = m_ce_prev;
        fall2 = m_hist[TAP+1] & !m_hist[TAP];
        m_ack = 0;
        if (fall2 && m_busy && !m_we) m_rdata = m_dprev;
        if (ce) begin
            if (m_busy && m_we && m_addr == 16'hFE40) m_slow = (m_dout[2:0] == 3'd0) ? 15 : 1;
            else if (m_slow > 0) m_slow = m_slow - 1;
        end
        if (m_busy && ce) begin
            m_ack = 1; m_busy = 0;
        end else if (!m_busy && cs) begin
            if (req) begin
                m_busy = 1; m_addr = req_addr; m_we = req_we; m_dout = req_dout;
            end else begin
                m_addr = 16'hFFFF; m_we = 0; m_dout = 8'hFF;
            end
        end
        m_hist = {m_hist[14:0], phi_in};
        m_dprev = data_in; m_ce_prev = ce; ev_ce = ce;
    endtask

    int   cyc = 0, ack_cnt = 0, slow_hits = 0, fall_cyc = 0;
    int   phi_cnt = 0, phi_hi = 20, phi_lo = 20;
    bit   rand_phi = 0, rand_din = 0;
    logic ack_prev = 0, slow_prev = 0;

    task automatic step();
        logic [37:0] act_v, exp_v;
        @(posedge cpu_clk); #1;
        cyc++;
        model_update();
        if (ev_ce && slow_prev) slow_hits++;
        exp_v = {m_ack, m_addr, !m_we, m_dout, m_we & m_hist[0], m_rdata, (m_slow != 0),
                 ~m_hist[TAP], m_hist[TAP]};
        act_v = {ack, bus_addr, bus_rnw, bus_dout, bus_doe, rdata, slow, phi1_out, phi2_out};
        chk("cycle", act_v, exp_v);
        if (ack) begin
            ack_cnt++;
            chk("ack_gap", ack_prev, 1'b0);
        end
        ack_prev = ack; slow_prev = slow;
        phi_cnt++;
        if (phi_in && phi_cnt >= phi_hi) begin
            phi_in = 0; phi_cnt = 0; fall_cyc = cyc;
            if (rand_phi) phi_lo = $urandom_range(6, 30);
        end else if (!phi_in && phi_cnt >= phi_lo) begin
            phi_in = 1; phi_cnt = 0;
            if (rand_phi) phi_hi = $urandom_range(6, 30);
        end
        if (rand_din) data_in = 8'($urandom);
    endtask

    // Present a request and hold it until ack; req drops in the ack cycle itself.
    task automatic txn(input logic [15:0] a, input logic w, input logic [7:0] wd,
                       output int acks, output int ack_cyc);
        req = 1; req_addr = a; req_we = w; req_dout = wd; acks = 0; ack_cyc = -1;
        for (int n = 0; n < 400 && acks == 0; n++) begin
            step();
            if (ack) begin acks++; ack_cyc = cyc; end
        end
        req = 0;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wd;
        logic [7:0]  din;
        logic [7:0]  exp_rd;
        int          exp_slow;
    } vec_t;
    vec_t vecs[7];

    initial begin
        int got, got2, t1, t2, a0, n_ce, cnt_a, cyc_a;
        vecs[0] = '{16'hFE4D, 1'b0, 8'h00, 8'h5A, 8'h5A, 0};
        vecs[1] = '{16'h3000, 1'b1, 8'hA5, 8'h00, 8'h5A, 0};
        vecs[2] = '{16'hFE40, 1'b1, 8'h08, 8'h00, 8'h5A, 15};
        vecs[3] = '{16'hFE40, 1'b1, 8'h0B, 8'h00, 8'h5A, 1};
        vecs[4] = '{16'h1234, 1'b0, 8'h00, 8'hC3, 8'hC3, 0};
        vecs[5] = '{16'hFE40, 1'b1, 8'h00, 8'h00, 8'hC3, 15};
        vecs[6] = '{16'hFE41, 1'b1, 8'h00, 8'h00, 8'hC3, 0};

        repeat (3) step();
        chk("rst_addr", bus_addr, 16'hFFFF);
        chk("rst_rnw", bus_rnw, 1'b1);
        chk("rst_dout", bus_dout, 8'hFF);
        chk("rst_doe", bus_doe, 1'b0);
        chk("rst_ack", ack, 1'b0);
        chk("rst_rdata", rdata, 8'hFF);
        chk("rst_slow", slow, 1'b0);
        chk("rst_phi1", phi1_out, 1'b1);
        chk("rst_phi2", phi2_out, 1'b0);
        cpu_reset = 0;

        a0 = ack_cnt;
        repeat (200) step();
        chk("idle_no_ack", ack_cnt - a0, 0);
        chk("idle_park", {bus_addr, bus_rnw, bus_dout}, {16'hFFFF, 1'b1, 8'hFF});

        for (int i = 0; i < 7; i++) begin
            data_in = vecs[i].din;
            a0 = ack_cnt;
            txn(vecs[i].addr, vecs[i].we, vecs[i].wd, got, t1);
            chk("vec_ack", got, 1);
            chk("vec_rdata", rdata, vecs[i].exp_rd);
            slow_hits = 0; n_ce = 0;
            for (int k = 0; k < 3000 && n_ce < 20; k++) begin
                step();
                if (ev_ce) n_ce++;
            end
            chk("vec_slow_ends", slow_hits, vecs[i].exp_slow);
            chk("vec_slow_low", slow, 1'b0);
            chk("vec_park", {bus_addr, bus_rnw, bus_dout}, {16'hFFFF, 1'b1, 8'hFF});
            chk("vec_acks", ack_cnt - a0, 1);
        end

        // Back-to-back reads lose no bus period
        data_in = 8'h11;
        txn(16'h2000, 1'b0, 8'h00, got, t1);
        data_in = 8'h22;
        txn(16'h2001, 1'b0, 8'h00, got2, t2);
        chk("b2b_acks", got + got2, 2);
        chk("b2b_gap", t2 - t1, 40);
        chk("b2b_rdata", rdata, 8'h22);

        // One stretched 40/40 period while a read is in flight
        data_in = 8'h3C; a0 = ack_cnt;
        req = 1; req_addr = 16'h4000; req_we = 0;
        for (int k = 0; k < 200 && !m_busy; k++) step();
        cnt_a = phi_cnt; cyc_a = cyc;
        chk("stretch_low_at_start", phi_in, 1'b0);
        phi_hi = 40; phi_lo = 40;
        for (int k = 0; k < 300 && ack_cnt == a0; k++) step();
        req = 0; phi_hi = 20; phi_lo = 20;
        chk("stretch_ack_cyc", cyc, cyc_a + (40 - cnt_a) + 40 + NPHI);
        chk("stretch_fall_gap", cyc - fall_cyc, NPHI);
        chk("stretch_rdata", rdata, 8'h3C);
        repeat (100) step();
        chk("stretch_acks", ack_cnt - a0, 1);

        // Reset in the middle of an active read
        data_in = 8'h00;
        txn(16'hFE40, 1'b1, 8'h00, got, t1);
        chk("rmid_fe40_ack", got, 1);
        data_in = 8'h77; req = 1; req_addr = 16'h5000; req_we = 0;
        for (int k = 0; k < 200 && !m_busy; k++) step();
        repeat (10) step();
        chk("rmid_slow_before", slow, 1'b1);
        a0 = ack_cnt;
        cpu_reset = 1;
        step();
        chk("rmid_ack", ack, 1'b0);
        chk("rmid_park", {bus_addr, bus_rnw, bus_dout}, {16'hFFFF, 1'b1, 8'hFF});
        chk("rmid_slow", slow, 1'b0);
        cpu_reset = 0; req = 0;
        repeat (100) step();
        chk("rmid_no_ack", ack_cnt - a0, 0);
        data_in = 8'h99;
        txn(16'h5001, 1'b0, 8'h00, got, t1);
        chk("rmid_after_ack", got, 1);
        chk("rmid_after_rdata", rdata, 8'h99);

        // Random traffic with random Phi0 phases and per-cycle data pin noise
        rand_phi = 1; rand_din = 1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 60)) step();
            txn(($urandom_range(0, 3) == 0) ? 16'hFE40 : 16'($urandom),
                1'($urandom), 8'($urandom), got, t1);
            chk("rnd_ack", got, 1);
        end
        rand_phi = 0; rand_din = 0;
        repeat (300) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
